seq_mul_unsigned_r4: RTL and testbench

- Sequential radix-4 unsigned shift-add multiplier. It sits directly downstream of the generated two-bit accumulation layer and consumes its layer_sum.
- Each cycle, the layer forms A*{b1,b0} from the two lowest pending multiplier bits. This block adds that into a running high word, shifts the product register right by 2, and iterates WIDTH_B/2 times.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/seq_mul_pkg.sv | 15 +
 rtl/seq_mul_unsigned_r4_layer.sv | 21 ++
 rtl/seq_mul_unsigned_r4.sv | 115 +++++++++++
 tb/tb_seq_mul_unsigned_r4.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and elaboration helpers for the sequential radix-4 multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 retires two multiplier bits per iteration, so WIDTH_B must be even.
    function automatic bit width_b_ok(input int w);
        return (w >= 2) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/seq_mul_unsigned_r4_layer.sv
// Two-bit accumulation layer: layer_sum = a*{b_high,b_low} + cin, purely combinational.
module acc_layer_unsigned_x2 #(
    parameter int WIDTH_A = 8
) (
    input  logic [WIDTH_A-1:0] a,
    input  logic               b_low,
    input  logic               b_high,
    input  logic               cin,
    output logic [WIDTH_A+1:0] layer_sum
);

    logic [WIDTH_A+1:0] pp0;
    logic [WIDTH_A+1:0] pp1;

    always_comb begin
        pp0       = b_low  ? {2'b00, a}       : '0;
        pp1       = b_high ? {1'b0, a, 1'b0}  : '0;
        layer_sum = pp0 + pp1 + {{(WIDTH_A+1){1'b0}}, cin};
    end

endmodule

// File: rtl/seq_mul_unsigned_r4.sv
// Sequential radix-4 unsigned shift-add multiplier with valid/ready on both sides.
module seq_mul_unsigned_r4
    import seq_mul_pkg::*;
#(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int CNT_W   = $clog2(WIDTH_B/2) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy,
    output state_t                     dbg_state
);

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_B/2 - 1);

    if (!width_b_ok(WIDTH_B) || (WIDTH_A < 2)) begin : g_bad_width
        $error("seq_mul_unsigned_r4: WIDTH_B must be even and >= 2, WIDTH_A >= 2");
    end

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      p;
    logic [PW-1:0]      p_next;
    logic [WIDTH_A-1:0] a_reg;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic [WIDTH_A-1:0] hi;
    logic [WIDTH_A+1:0] layer_sum;
    logic [WIDTH_A+1:0] sum;

    acc_layer_unsigned_x2 #(.WIDTH_A(WIDTH_A)) u_layer (
        .a        (a_reg),
        .b_low    (p[0]),
        .b_high   (p[1]),
        .cin      (1'b0),
        .layer_sum(layer_sum)
    );

    // Cannot overflow: hi + 3*A_max <= 4*(2^WIDTH_A - 1).
    assign hi  = p[PW-1:WIDTH_B];
    assign sum = {2'b00, hi} + layer_sum;

    if (WIDTH_B == 2) begin : g_shift_narrow
        assign p_next = sum;
    end else begin : g_shift_wide
        assign p_next = {sum, p[WIDTH_B-1:2]};
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid holds its data until taken, and ready never looks at valid.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p     <= '0;
            a_reg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg <= a;
                p     <= {{WIDTH_A{1'b0}}, b};
                cnt   <= '0;
            end else if (state == RUN) begin
                p   <= p_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign product   = p;
    assign busy      = (state == RUN);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_mul_unsigned_r4.sv
// Bench for seq_mul_unsigned_r4: directed vectors on an 8x8 instance, random
// backpressure runs on 8x8 and 6x10 instances against a product scoreboard.
module tb_seq_mul_unsigned_r4;
    import seq_mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_v [2];
    logic        in_ready_v [2];
    logic [7:0]  a_v [2];
    logic [9:0]  b_v [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [15:0] product_v [2];
    logic        busy_v [2];
    state_t      state_v [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    seq_mul_unsigned_r4 #(.WIDTH_A(8), .WIDTH_B(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0][7:0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .product(product_v[0]), .busy(busy_v[0]), .dbg_state(state_v[0])
    );

    seq_mul_unsigned_r4 #(.WIDTH_A(6), .WIDTH_B(10)) u_dut610 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][5:0]), .b(b_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .product(product_v[1]), .busy(busy_v[1]), .dbg_state(state_v[1])
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Waits (bounded) for out_valid on the 8x8 instance; returns cycles waited and RUN cycles seen.
    task automatic wait_valid(input string name, output int lat, output int run_cyc);
        lat = 0;
        run_cyc = 0;
        while (!out_valid_v[0] && lat < 40) begin
            if (busy_v[0]) run_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid_v[0]) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Presents one operand pair from IDLE and leaves the bench just after the accept edge.
    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        a_v[0] = a;
        b_v[0] = {2'b00, b};
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        a_v[0] = 8'($urandom_range(0, 255));
        b_v[0] = 10'($urandom_range(0, 255));
    endtask

    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        int lat, run_cyc;
        out_ready_v[0] = 1'b1;
        accept_op(a, b);
        wait_valid(name, lat, run_cyc);
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_busy_cycles"}, 64'(run_cyc), 64'd4);
        check({name, "_product"}, 64'(product_v[0]), 64'(exp));
        @(negedge clk);
        check({name, "_back_idle"}, 64'({out_valid_v[0], in_ready_v[0]}), 64'b01);
    endtask

    task automatic rand_run(input int k, input int wa, input int wb, input int n, input string name);
        logic [15:0] exp_q [$];
        logic [15:0] ax, bx;
        int sent = 0, got = 0, cyc = 0;
        logic acc, del;
        logic [15:0] prod;
        acc = 1'b0;
        while ((sent < n || got < n) && cyc < n * 40) begin
            @(negedge clk);
            cyc++;
            if (acc) in_valid_v[k] = 1'b0;
            if (!in_valid_v[k] && sent < n && $urandom_range(0, 3) != 0) begin
                in_valid_v[k] = 1'b1;
                a_v[k] = 8'($urandom_range(0, (1 << wa) - 1));
                b_v[k] = 10'($urandom_range(0, (1 << wb) - 1));
            end
            out_ready_v[k] = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid_v[k] && in_ready_v[k];
            del  = out_valid_v[k] && out_ready_v[k];
            prod = product_v[k];
            if (acc) begin
                ax = 16'(a_v[k]);
                bx = 16'(b_v[k]);
                exp_q.push_back(ax * bx);
                sent++;
            end
            if (del) begin
                if (exp_q.size() == 0) check({name, "_extra_result"}, 64'(prod), 64'hdead_0000);
                else check({name, "_product"}, 64'(prod), 64'(exp_q.pop_front()));
                got++;
            end
        end
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        check({name, "_result_count"}, 64'(got), 64'(n));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs [7];
    int   lat, run_cyc;
    logic seen_valid;

    initial begin
        vecs[0] = '{a: 8'd13,   b: 8'd10,   exp: 16'd130};
        vecs[1] = '{a: 8'd255,  b: 8'd255,  exp: 16'hFE01};
        vecs[2] = '{a: 8'd0,    b: 8'hA5,   exp: 16'd0};
        vecs[3] = '{a: 8'hC3,   b: 8'd0,    exp: 16'd0};
        vecs[4] = '{a: 8'd1,    b: 8'd1,    exp: 16'd1};
        vecs[5] = '{a: 8'd128,  b: 8'd2,    exp: 16'd256};
        vecs[6] = '{a: 8'd170,  b: 8'd85,   exp: 16'd14450};

        for (int k = 0; k < 2; k++) begin
            in_valid_v[k] = 1'b0;
            out_ready_v[k] = 1'b0;
            a_v[k] = '0;
            b_v[k] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("reset_product", 64'(product_v[0]), 64'd0);
        check("reset_busy", 64'(busy_v[0]), 64'd0);
        check("reset_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("reset_state", 64'(state_v[0]), 64'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure hold, then back-to-back load on the releasing edge
        out_ready_v[0] = 1'b0;
        accept_op(8'd200, 8'd3);
        wait_valid("bp", lat, run_cyc);
        for (int i = 0; i < 6; i++) begin
            check("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
            check("bp_product", 64'(product_v[0]), 64'd600);
            check("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
            @(negedge clk);
        end
        in_valid_v[0] = 1'b1;
        a_v[0] = 8'd7;
        b_v[0] = 10'd9;
        out_ready_v[0] = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        check("b2b_reload", 64'({busy_v[0], out_valid_v[0]}), 64'b10);
        wait_valid("b2b", lat, run_cyc);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_product", 64'(product_v[0]), 64'd63);
        @(negedge clk);

        // Reset during the second RUN cycle drops the operation
        out_ready_v[0] = 1'b1;
        accept_op(8'd99, 8'd77);
        @(negedge clk);
        check("midrun_busy", 64'(busy_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_state", 64'(state_v[0]), 64'(IDLE));
        check("midrun_rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_v[0] || busy_v[0]) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("midrun_no_output", 64'(seen_valid), 64'd0);
        do_op("after_rst", 8'd5, 8'd6, 16'd30);

        fork
            rand_run(0, 8, 8, 1000, "rand8x8");
            rand_run(1, 6, 10, 1000, "rand6x10");
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
